// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the word-index PC, buffers {pc, instr} pairs for decode.
// Define IFU_PERF_CNT_EN to add fetchCount/stallCount performance counters.
module instruction_fetch_unit #(
    parameter int unsigned    ADDR_W    = 10,
    parameter int unsigned    FQ_DEPTH  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]    HALT_INSN = 32'h00000073
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              startIn,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic [31:0]       imemData,
    input  logic              redirectValid,
    input  logic [ADDR_W-1:0] redirectTarget,
    output logic              instrValid,
    output logic [31:0]       instrOut,
    output logic [ADDR_W-1:0] pcOut,
    input  logic              decodeReady,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]       fetchCount,
    output logic [31:0]       stallCount,
`endif
    output logic              halted
);

    localparam int unsigned PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [CW-1:0]     count_q;
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     rptr_q;
    logic [31:0]       iq_mem [FQ_DEPTH];
    logic [ADDR_W-1:0] pq_mem [FQ_DEPTH];
    logic [31:0]       instr_hold;
    logic [ADDR_W-1:0] pc_hold;
    logic              full;
    logic              pop;
    logic              push;

    assign instrValid = (count_q != '0);
    assign full       = (count_q == CW'(FQ_DEPTH));
    // a redirect voids any pop: the head is discarded with the flush
    assign pop        = instrValid && decodeReady && !redirectValid;
    assign push       = (state_q == RUN) && !redirectValid && (!full || pop);

    assign imemAddr = pc_q;
    assign halted   = (state_q == HALT);
    assign instrOut = instrValid ? iq_mem[rptr_q] : instr_hold;
    assign pcOut    = instrValid ? pq_mem[rptr_q] : pc_hold;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (startIn) state_d = RUN;
            RUN: begin
                if (push && imemData == HALT_INSN) state_d = HALT;
            end
            HALT: if (startIn || redirectValid) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            instr_hold <= '0;
            pc_hold    <= '0;
        end else begin
            state_q <= state_d;
            if (instrValid) begin
                instr_hold <= iq_mem[rptr_q];
                pc_hold    <= pq_mem[rptr_q];
            end
            if (redirectValid) begin
                count_q <= '0;
                wptr_q  <= '0;
                rptr_q  <= '0;
                pc_q    <= redirectTarget;
            end else begin
                if (push) begin
                    wptr_q <= wptr_q + PW'(1);
                    pc_q   <= pc_q + ADDR_W'(1);
                end
                if (pop) rptr_q <= rptr_q + PW'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // storage needs no reset: reads are masked by count
    always_ff @(posedge clk) begin
        if (push) begin
            iq_mem[wptr_q] <= imemData;
            pq_mem[wptr_q] <= pc_q;
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fetchCount <= '0;
            stallCount <= '0;
        end else begin
            if (push) fetchCount <= fetchCount + 32'd1;
            if (state_q == RUN && full && !pop) stallCount <= stallCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational memory model.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rstN;
    logic        startIn;
    logic [9:0]  imemAddr;
    logic [31:0] imemData;
    logic        redirectValid;
    logic [9:0]  redirectTarget;
    logic        instrValid;
    logic [31:0] instrOut;
    logic [9:0]  pcOut;
    logic        decodeReady;
    logic        halted;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetchCount;
    logic [31:0] stallCount;
`endif

    logic [31:0] mem [1024];
    int checks = 0;
    int errors = 0;

    assign imemData = mem[imemAddr];

    instruction_fetch_unit dut (
        .clk(clk),
        .rstN(rstN),
        .startIn(startIn),
        .imemAddr(imemAddr),
        .imemData(imemData),
        .redirectValid(redirectValid),
        .redirectTarget(redirectTarget),
        .instrValid(instrValid),
        .instrOut(instrOut),
        .pcOut(pcOut),
        .decodeReady(decodeReady),
`ifdef IFU_PERF_CNT_EN
        .fetchCount(fetchCount),
        .stallCount(stallCount),
`endif
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        #3;
        chk("rst_valid", 32'(instrValid), 32'd0);
        chk("rst_addr", 32'(imemAddr), 32'd0);
        chk("rst_pc", 32'(pcOut), 32'd0);
        chk("rst_instr", instrOut, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        rstN = 1'b1;
        step();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 | i;
        mem[0] = 32'h00002083;
        mem[1] = 32'h00208133;
        mem[2] = 32'h002081b3;
        mem[3] = 32'h0020c233;
        mem[4] = 32'h004182b3;
        mem[5] = 32'h00000073;

        startIn = 0;
        redirectValid = 0;
        redirectTarget = '0;
        decodeReady = 0;
        rstN = 0;
        #2;
        do_reset();

        // T1: straight-line program to halt
        startIn = 1;
        decodeReady = 1;
        step();
        startIn = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t1_valid", 32'(instrValid), 32'd1);
            chk("t1_pc", 32'(pcOut), 32'(k));
            chk("t1_instr", instrOut, mem[k]);
        end
        chk("t1_halted", 32'(halted), 32'd1);
        step();
        chk("t1_drain", 32'(instrValid), 32'd0);
        chk("t1_addr", 32'(imemAddr), 32'd6);
        chk("t1_hold_pc", 32'(pcOut), 32'd5);
        chk("t1_hold_instr", instrOut, 32'h00000073);
        step();
        chk("t1_nofetch", 32'(instrValid), 32'd0);
        chk("t1_addr2", 32'(imemAddr), 32'd6);
        // restart from HALT resumes at PC 6
        startIn = 1;
        step();
        startIn = 0;
        chk("t1_run", 32'(halted), 32'd0);
        step();
        chk("t1_resume", 32'(pcOut), 32'd6);

        // T2: backpressure fills the queue
        do_reset();
        startIn = 1;
        decodeReady = 0;
        step();
        startIn = 0;
        for (int k = 0; k < 6; k++) step();
        chk("t2_addr", 32'(imemAddr), 32'd2);
        chk("t2_valid", 32'(instrValid), 32'd1);
        chk("t2_head", 32'(pcOut), 32'd0);
        chk("t2_head_instr", instrOut, mem[0]);
`ifdef IFU_PERF_CNT_EN
        chk("t6_fetch", fetchCount, 32'd2);
        chk("t6_stall", stallCount, 32'd4);
`endif
        decodeReady = 1;
        step();
        chk("t2_pc1", 32'(pcOut), 32'd1);
        step();
        chk("t2_pc2", 32'(pcOut), 32'd2);
        step();
        chk("t2_pc3", 32'(pcOut), 32'd3);

        // T3: redirect discards queued pcs 3,4
        decodeReady = 0;
        step();
        chk("t3_head", 32'(pcOut), 32'd3);
        chk("t3_addr", 32'(imemAddr), 32'd5);
        redirectValid = 1;
        redirectTarget = 10'd9;
        step();
        redirectValid = 0;
        decodeReady = 1;
        chk("t3_flush", 32'(instrValid), 32'd0);
        chk("t3_addr9", 32'(imemAddr), 32'd9);
        chk("t3_holdpc", 32'(pcOut), 32'd3);
        step();
        chk("t3_pc9", 32'(pcOut), 32'd9);
        chk("t3_instr9", instrOut, mem[9]);
        step();
        chk("t3_pc10", 32'(pcOut), 32'd10);

        // T4: wrap past the top of memory
        redirectValid = 1;
        redirectTarget = 10'd1023;
        step();
        redirectValid = 0;
        chk("t4_flush", 32'(instrValid), 32'd0);
        chk("t4_addr", 32'(imemAddr), 32'd1023);
        step();
        chk("t4_pc1023", 32'(pcOut), 32'd1023);
        chk("t4_instr", instrOut, mem[1023]);
        step();
        chk("t4_pc0", 32'(pcOut), 32'd0);
        chk("t4_instr0", instrOut, mem[0]);

        // T5: async reset with full queue
        decodeReady = 0;
        step();
        step();
        chk("t5_full", 32'(instrValid), 32'd1);
        rstN = 0;
        #1;
        chk("t5_valid", 32'(instrValid), 32'd0);
        chk("t5_addr", 32'(imemAddr), 32'd0);
        chk("t5_pc", 32'(pcOut), 32'd0);
        #2;
        rstN = 1;
        decodeReady = 1;
        step();
        step();
        step();
        chk("t5_idle_valid", 32'(instrValid), 32'd0);
        chk("t5_idle_addr", 32'(imemAddr), 32'd0);
        startIn = 1;
        step();
        startIn = 0;
        step();
        chk("t5_restart_v", 32'(instrValid), 32'd1);
        chk("t5_restart_pc", 32'(pcOut), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
